// File: rtl/pc_sequencer_pkg.sv
// Shared constants and the next-PC select encoding for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int          PC_W_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_target_mux.sv
// Forms jump/branch/JR targets from pc+4 and picks the winner: JR > J > branch > sequential.
module pc_target_mux
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc_plus4,
    input  logic            jump,
    input  logic [PC_W-5:0] jtarget,
    input  logic            branch,
    input  logic [PC_W-1:0] boffset,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_addr,
    output logic [PC_W-1:0] tgt,
    output logic            req,
    output pc_sel_e         sel,
    output logic            jr_misalign
);

    logic [PC_W-1:0] jt;
    logic [PC_W-1:0] bt;
    logic [PC_W-1:0] rt;

    assign jt = {pc_plus4[PC_W-1:PC_W-4], jtarget};
    assign bt = pc_plus4 + boffset;
    assign rt = {jr_addr[PC_W-1:2], 2'b00};

    // Raw alignment flag; the top qualifies it with the winning select.
    assign jr_misalign = jr && (jr_addr[1:0] != 2'b00);

    always_comb begin
        sel = SEL_SEQ;
        tgt = pc_plus4;
        if (jr) begin
            sel = SEL_JR;
            tgt = rt;
        end else if (jump) begin
            sel = SEL_J;
            tgt = jt;
        end else if (branch) begin
            sel = SEL_BR;
            tgt = bt;
        end
    end

    assign req = jr || jump || branch;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with a single-entry redirect buffer that holds a redirect across a stall.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [PC_W-5:0] jtarget_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] boffset_i,
    input  logic            jr_i,
    input  logic [PC_W-1:0] jr_addr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            redirect_o,
    output logic            pending_o,
    output logic            misalign_o
);

    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_tgt_reg, pend_tgt_next;
    logic            pending_reg, pending_next;
    logic            redirect_reg, redirect_next;
    logic            misalign_reg, misalign_next;

    logic [PC_W-1:0] tgt;
    logic            req;
    pc_sel_e         sel;
    logic            jr_misalign;

    assign pc_plus4_o = pc_reg + PC_W'(4);

    pc_target_mux #(
        .PC_W (PC_W)
    ) u_target_mux (
        .pc_plus4    (pc_plus4_o),
        .jump        (jump_i),
        .jtarget     (jtarget_i),
        .branch      (branch_i),
        .boffset     (boffset_i),
        .jr          (jr_i),
        .jr_addr     (jr_addr_i),
        .tgt         (tgt),
        .req         (req),
        .sel         (sel),
        .jr_misalign (jr_misalign)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_reg       <= RESET_PC;
            pend_tgt_reg <= '0;
            pending_reg  <= 1'b0;
            redirect_reg <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            pend_tgt_reg <= pend_tgt_next;
            pending_reg  <= pending_next;
            redirect_reg <= redirect_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        pc_next       = pc_reg;
        pend_tgt_next = pend_tgt_reg;
        pending_next  = pending_reg;
        redirect_next = 1'b0;
        // Sticky: flagged even when the JR is buffered or later dropped.
        misalign_next = misalign_reg || ((sel == SEL_JR) && jr_misalign);

        if (stall_i) begin
            // Only the first redirect seen during a stall is kept.
            if (!pending_reg && req) begin
                pend_tgt_next = tgt;
                pending_next  = 1'b1;
            end
        end else if (pending_reg) begin
            pc_next       = pend_tgt_reg;
            pending_next  = 1'b0;
            redirect_next = 1'b1;
        end else if (req) begin
            pc_next       = tgt;
            redirect_next = 1'b1;
        end else begin
            pc_next = pc_plus4_o;
        end
    end

    assign pc_o       = pc_reg;
    assign pending_o  = pending_reg;
    assign redirect_o = redirect_reg;
    assign misalign_o = misalign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle model comparison plus hand-computed checkpoints.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, jump_i, branch_i, jr_i;
    logic [27:0] jtarget_i;
    logic [31:0] boffset_i, jr_addr_i;
    logic [31:0] pc_o, pc_plus4_o;
    logic        redirect_o, pending_o, misalign_o;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Model state
    logic [31:0] m_pc, m_ptgt;
    logic        m_pend, m_redir, m_mis;

    pc_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stall_i    (stall_i),
        .jump_i     (jump_i),
        .jtarget_i  (jtarget_i),
        .branch_i   (branch_i),
        .boffset_i  (boffset_i),
        .jr_i       (jr_i),
        .jr_addr_i  (jr_addr_i),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .redirect_o (redirect_o),
        .pending_o  (pending_o),
        .misalign_o (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: next PC straight from the priority/buffering rules.
    always @(posedge clk_i or negedge rst_i) begin
        logic [31:0] nxt, t;
        logic        r;
        if (!rst_i) begin
            m_pc = 32'h0; m_ptgt = 32'h0; m_pend = 0; m_redir = 0; m_mis = 0;
        end else begin
            nxt = m_pc + 32'd4;
            r = jr_i | jump_i | branch_i;
            if (jr_i)          t = jr_addr_i & 32'hFFFF_FFFC;
            else if (jump_i)   t = (nxt & 32'hF000_0000) | {4'h0, jtarget_i};
            else if (branch_i) t = nxt + boffset_i;
            else               t = nxt;
            if (jr_i && (jr_addr_i % 4 != 0)) m_mis = 1;
            if (stall_i) begin
                if (!m_pend && r) begin m_pend = 1; m_ptgt = t; end
                m_redir = 0;
            end else if (m_pend) begin
                m_pc = m_ptgt; m_pend = 0; m_redir = 1;
            end else begin
                m_pc = t; m_redir = r;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (started && rst_i) begin
            chk("model_pc", pc_o, m_pc);
            chk("model_pc4", pc_plus4_o, m_pc + 32'd4);
            chk("model_redirect", {31'b0, redirect_o}, {31'b0, m_redir});
            chk("model_pending", {31'b0, pending_o}, {31'b0, m_pend});
            chk("model_misalign", {31'b0, misalign_o}, {31'b0, m_mis});
            $display("cyc pc=%h redir=%b pend=%b mis=%b", pc_o, redirect_o, pending_o, misalign_o);
        end
    end

    task automatic idle_in();
        stall_i = 0; jump_i = 0; branch_i = 0; jr_i = 0;
        jtarget_i = '0; boffset_i = '0; jr_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_jr(input logic [31:0] a);
        idle_in(); jr_i = 1; jr_addr_i = a; tick();
    endtask

    initial begin
        idle_in();
        rst_i = 0;
        repeat (2) @(posedge clk_i);
        #6 rst_i = 1;
        started = 1;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_redir", {31'b0, redirect_o}, 32'h0);
        tick(); chk("seq_4", pc_o, 32'h4);
        tick(); chk("seq_8", pc_o, 32'h8);
        tick(); chk("seq_12", pc_o, 32'hC);
        chk("seq_redir", {31'b0, redirect_o}, 32'h0);

        do_jr(32'h1000_0040);
        chk("jr_pc", pc_o, 32'h1000_0040);
        idle_in(); jump_i = 1; jtarget_i = 28'h0000100; tick();
        chk("jump_pc", pc_o, 32'h1000_0100);
        chk("jump_redir", {31'b0, redirect_o}, 32'h1);
        idle_in(); tick();
        chk("jump_redir_drop", {31'b0, redirect_o}, 32'h0);
        chk("after_jump_seq", pc_o, 32'h1000_0104);

        do_jr(32'h20);
        idle_in(); branch_i = 1; boffset_i = 32'hFFFF_FFF0; tick();
        chk("branch_pc", pc_o, 32'h14);
        do_jr(32'h20);
        idle_in(); branch_i = 1; boffset_i = 32'hFFFF_FFF0; jump_i = 1; jtarget_i = 28'h0000080; tick();
        chk("jump_over_branch", pc_o, 32'h80);

        idle_in(); stall_i = 1; jr_i = 1; jr_addr_i = 32'h200; tick();
        chk("stall1_pc", pc_o, 32'h80);
        chk("stall1_pend", {31'b0, pending_o}, 32'h1);
        idle_in(); stall_i = 1; jump_i = 1; jtarget_i = 28'h0000400; tick();
        chk("stall2_pc", pc_o, 32'h80);
        idle_in(); stall_i = 1; tick();
        chk("stall3_pend", {31'b0, pending_o}, 32'h1);
        idle_in(); branch_i = 1; boffset_i = 32'h100; tick();
        chk("release_pc", pc_o, 32'h200);
        chk("release_redir", {31'b0, redirect_o}, 32'h1);
        chk("release_pend", {31'b0, pending_o}, 32'h0);

        do_jr(32'h303);
        chk("misjr_pc", pc_o, 32'h300);
        chk("misjr_flag", {31'b0, misalign_o}, 32'h1);
        idle_in(); tick(); tick();
        chk("mis_sticky", {31'b0, misalign_o}, 32'h1);

        do_jr(32'hFFFF_FFFC);
        idle_in(); tick();
        chk("wrap_pc", pc_o, 32'h0);
        idle_in(); jump_i = 1; jtarget_i = 28'h0000010; tick();
        chk("wrap_jt", pc_o, 32'h10);
        do_jr(32'hFFFF_FFF8);
        idle_in(); branch_i = 1; boffset_i = 32'h8; tick();
        chk("bt_wrap", pc_o, 32'h4);

        idle_in(); stall_i = 1; branch_i = 1; boffset_i = 32'h40; tick();
        chk("pre_rst_pend", {31'b0, pending_o}, 32'h1);
        #2 rst_i = 0;
        #1;
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_pend", {31'b0, pending_o}, 32'h0);
        chk("async_rst_mis", {31'b0, misalign_o}, 32'h0);
        idle_in();
        #1 rst_i = 1;
        tick(); chk("restart_4", pc_o, 32'h4);
        tick(); chk("restart_8", pc_o, 32'h8);
        chk("restart_pend", {31'b0, pending_o}, 32'h0);

        @(negedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
